// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with flush sweep.
//
// Lookup is purely combinational from the registered table: hit_o/target_o
// reflect pc_i against the state as of the last clock edge. A resolution on
// res_i (valid_i) updates, allocates or deletes one way of the indexed set.
// flush_i starts a sweep that clears one set per cycle; busy_o is high while
// it runs, and lookups and updates are suppressed during the sweep.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   flush_i      invalidate the whole table (sweep of SETS cycles)
//   pc_i         lookup address
//   valid_i      res_i carries a resolved branch this cycle
//   del_entry_i  with valid_i: delete the entry for res_i.pc
//   res_i        resolved branch {pc, target}
//   hit_o        lookup of pc_i hits
//   target_o     predicted target[XLEN-1:OFFSET], 0 on miss
//   busy_o       flush sweep in progress
//
// Build option: define BTB_PLRU_EN for tree pseudo-LRU replacement (touched
// on lookup hits and writes); otherwise a per-set round-robin pointer.

localparam int unsigned XLEN     = 32;
localparam int unsigned OFFSET   = 2;
localparam int unsigned BTB_BITS = 4;

typedef struct packed {
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
} resolution_t;

module btb_assoc #(
  parameter int unsigned SET_BITS = BTB_BITS,
  parameter int unsigned WAYS     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   valid_i,
  input  logic                   del_entry_i,
  input  resolution_t            res_i,
  output logic                   hit_o,
  output logic [XLEN-OFFSET-1:0] target_o,
  output logic                   busy_o
);

  localparam int unsigned SETS     = 1 << SET_BITS;
  localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_W    = XLEN - SET_BITS - OFFSET;
  localparam int unsigned TGT_W    = XLEN - OFFSET;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]    tag_d   [SETS][WAYS];
  logic [TGT_W-1:0]    tgt_q   [SETS][WAYS];
  logic [TGT_W-1:0]    tgt_d   [SETS][WAYS];

`ifdef BTB_PLRU_EN
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  logic [PLRU_W-1:0] plru_q [SETS];
  logic [PLRU_W-1:0] plru_d [SETS];

  // Heap-ordered tree: node n has children 2n and 2n+1, bit n-1 points to
  // the subtree to evict next (0 = left, 1 = right).
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < WAY_BITS; l++) begin
      node = 2 * node + 32'(bits[node-1]);
    end
    return (WAYS > 1) ? WAY_BITS'(node - WAYS) : '0;
  endfunction

  // Point every node on the path away from the touched way.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_BITS-1:0] way);
    logic [PLRU_W-1:0] r;
    int unsigned       node;
    r    = bits;
    node = WAYS + 32'(way);
    if (WAYS > 1) begin
      for (int unsigned l = 0; l < WAY_BITS; l++) begin
        r[(node >> 1) - 1] = ~node[0];
        node = node >> 1;
      end
    end
    return r;
  endfunction
`else
  logic [WAY_BITS-1:0] rr_q [SETS];
  logic [WAY_BITS-1:0] rr_d [SETS];
`endif

  // Lookup path
  logic [SET_BITS-1:0] l_idx;
  logic [TAG_W-1:0]    l_tag;
  logic [WAYS-1:0]     l_match;
  logic [TGT_W-1:0]    l_tgt;
  logic [WAY_BITS-1:0] l_way;
  logic                l_hit;

  assign l_idx = pc_i[SET_BITS+OFFSET-1:OFFSET];
  assign l_tag = pc_i[XLEN-1:SET_BITS+OFFSET];

  always_comb begin
    l_match = '0;
    l_tgt   = '0;
    l_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      l_match[w] = valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag);
      if (l_match[w]) begin
        l_tgt = l_tgt | tgt_q[l_idx][w];
        l_way = WAY_BITS'(w);
      end
    end
  end

  assign l_hit    = (state_q == ST_IDLE) && ($countones(l_match) == 1);
  assign hit_o    = l_hit;
  assign target_o = l_hit ? l_tgt : '0;
  assign busy_o   = (state_q == ST_FLUSH);

  // Update path
  logic [SET_BITS-1:0] r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic [WAYS-1:0]     r_match;
  logic [WAY_BITS-1:0] r_way, free_way, victim, wr_way;
  logic                has_free, upd_touch;

  assign r_idx = res_i.pc[SET_BITS+OFFSET-1:OFFSET];
  assign r_tag = res_i.pc[XLEN-1:SET_BITS+OFFSET];

  always_comb begin
    r_match  = '0;
    r_way    = '0;
    free_way = '0;
    has_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      r_match[w] = valid_q[r_idx][w] && (tag_q[r_idx][w] == r_tag);
      if (r_match[w]) r_way = WAY_BITS'(w);
      if (!valid_q[r_idx][w]) begin
        has_free = 1'b1;
        free_way = WAY_BITS'(w);
      end
    end
`ifdef BTB_PLRU_EN
    victim = plru_victim(plru_q[r_idx]);
`else
    victim = (WAYS > 1) ? rr_q[r_idx] : '0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    wr_way    = '0;
    upd_touch = 1'b0;
`ifdef BTB_PLRU_EN
    plru_d = plru_q;
`else
    rr_d = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Flush wins over a simultaneous update.
        if (flush_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (valid_i) begin
          if (del_entry_i) begin
            if (|r_match) valid_d[r_idx][r_way] = 1'b0;
          end else begin
            wr_way = (|r_match) ? r_way : (has_free ? free_way : victim);
            valid_d[r_idx][wr_way] = 1'b1;
            tag_d[r_idx][wr_way]   = r_tag;
            tgt_d[r_idx][wr_way]   = res_i.target[XLEN-1:OFFSET];
            upd_touch              = 1'b1;
`ifndef BTB_PLRU_EN
            if (!(|r_match) && !has_free && (WAYS > 1)) rr_d[r_idx] = rr_q[r_idx] + 1'b1;
`endif
          end
        end
      end
      ST_FLUSH: begin
        valid_d[cnt_q] = '0;
`ifdef BTB_PLRU_EN
        plru_d[cnt_q] = '0;
`else
        rr_d[cnt_q] = '0;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_BITS'(SETS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef BTB_PLRU_EN
    // A write to the same set overrides the lookup touch.
    if (l_hit && !(upd_touch && (r_idx == l_idx))) begin
      plru_d[l_idx] = plru_touch(plru_q[l_idx], l_way);
    end
    if (upd_touch) plru_d[r_idx] = plru_touch(plru_q[r_idx], wr_way);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
`ifdef BTB_PLRU_EN
        plru_q[s] <= '0;
`else
        rr_q[s] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
`ifdef BTB_PLRU_EN
      plru_q <= plru_d;
`else
      rr_q <= rr_d;
`endif
    end
  end

  // Tags and targets are qualified by valid bits and need no reset.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  logic unused_bits;
`ifdef BTB_PLRU_EN
  assign unused_bits = ^{pc_i[OFFSET-1:0], res_i.pc[OFFSET-1:0], res_i.target[OFFSET-1:0]};
`else
  assign unused_bits = ^{pc_i[OFFSET-1:0], res_i.pc[OFFSET-1:0], res_i.target[OFFSET-1:0],
                         l_way, upd_touch};
`endif

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 The block SHALL have parameter SET_BITS, default BTB_BITS: log2 of the number of sets (SETS = 2^SET_BITS).
REQ-002 The block SHALL have parameter WAYS, default 2: ways per set; power of two, 1..8.
REQ-003 The block SHALL have port clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush_i, input, width 1: request to invalidate the whole table.
REQ-006 The block SHALL have port pc_i, input, width XLEN: lookup address.
REQ-007 The block SHALL have port valid_i, input, width 1: res_i carries a valid branch resolution this cycle.
REQ-008 The block SHALL have port del_entry_i, input, width 1: with valid_i, delete the entry for res_i.pc instead of writing it.
REQ-009 The block SHALL have port res_i, input, resolution_t: resolved branch, fields .pc and .target.
REQ-010 The block SHALL have port hit_o, output, width 1: lookup of pc_i hits.
REQ-011 The block SHALL have port target_o, output, width XLEN-OFFSET: predicted target[XLEN-1:OFFSET].
REQ-012 The block SHALL have port busy_o, output, width 1: flush sweep in progress.

Function
REQ-013 Set index SHALL be pc[SET_BITS+OFFSET-1:OFFSET]; tag SHALL be pc[XLEN-1:SET_BITS+OFFSET]; each way SHALL hold valid, tag and target[XLEN-1:OFFSET].
REQ-014 Lookup SHALL be combinational from registered state: hit_o=1 iff exactly one valid way in the indexed set has a matching tag; target_o SHALL be that way's target, else 0.
REQ-015 A write in cycle N SHALL be visible to lookup from cycle N+1; a same-cycle lookup SHALL see the old contents.
REQ-016 Update (valid_i=1, del_entry_i=0, busy_o=0) on a tag match SHALL overwrite the target in the matching way.
REQ-017 Update without a tag match SHALL allocate the lowest-index invalid way; if no way is invalid, it SHALL replace the victim selected by the replacement policy.
REQ-018 Delete (valid_i=1, del_entry_i=1) on a tag match SHALL clear only the matching way; on a miss it SHALL change nothing, including replacement state.
REQ-019 The table SHALL never hold two valid ways with the same tag in one set.
REQ-020 The FSM SHALL have states IDLE and FLUSH; in IDLE, flush_i=1 SHALL enter FLUSH with the set counter at 0.
REQ-021 In FLUSH, the block SHALL clear all ways and the replacement state of one set per cycle, counting 0..SETS-1, and SHALL return to IDLE after set SETS-1, i.e. exactly SETS cycles.
REQ-022 busy_o SHALL equal 1 exactly while in FLUSH; during FLUSH hit_o SHALL be 0, valid_i SHALL be ignored (the update is dropped) and flush_i SHALL be ignored.
REQ-023 flush_i and valid_i asserted together in IDLE SHALL make flush win and drop the update.
REQ-024 Default replacement SHALL be a per-set round-robin pointer of log2(WAYS) bits that advances by one, with wrap-around, only on a victim replacement.
REQ-025 When WAYS=1, the block SHALL behave as a direct-mapped BTB with no replacement state.

Reset
REQ-026 While rst_n_i=0, independent of clk_i, all valid bits, replacement state and the set counter SHALL be cleared and the FSM SHALL be IDLE.
REQ-027 Output values in reset SHALL be hit_o=0, target_o=0 and busy_o=0.
REQ-028 Reset asserted mid-flush SHALL abort the sweep immediately; after release the FSM SHALL be IDLE and busy_o=0.

Configuration
REQ-029 Macro BTB_PLRU_EN SHALL select the replacement policy.
REQ-030 With BTB_PLRU_EN defined, replacement SHALL be tree pseudo-LRU with WAYS-1 bits per set, touched on lookup hits and on writes.
REQ-031 Under BTB_PLRU_EN, a write SHALL take priority over a lookup hit to the same set in the same cycle.
REQ-032 Without BTB_PLRU_EN, replacement SHALL be round-robin per REQ-024, with no lookup-driven update.

Verification
(Test setup: XLEN=32, OFFSET=2, SET_BITS=4, WAYS=2, round-robin unless stated.)
REQ-033 The bench SHALL check: reset, then write pc 0x100 with target 0x200 -> next cycle lookup of 0x100 gives hit_o=1, target_o=0x80; lookup of 0x104 gives hit_o=0.
REQ-034 The bench SHALL check: write 0x100, 0x140 and 0x180 (all set 0) -> 0x140 and 0x180 hit and 0x100 misses (way 0 evicted); a further write of 0x1C0 evicts 0x140.
REQ-035 The bench SHALL check: write 0x100 and 0x140, delete 0x100 -> 0x100 misses and 0x140 still hits; delete 0x300 -> no state change.
REQ-036 The bench SHALL check: fill 4 sets, pulse flush_i -> busy_o=1 for exactly 16 cycles, hit_o=0 throughout, a write of 0x100 during the sweep is dropped, and all lookups miss afterwards.
REQ-037 The bench SHALL check: assert rst_n_i=0 at sweep cycle 5 -> busy_o=0 with no clock edge; after release a write then read of 0x100 hits.
REQ-038 The bench SHALL check with BTB_PLRU_EN: write 0x100 and 0x140, look up 0x100, write 0x180 -> 0x140 is evicted and 0x100 still hits.
